// File: rtl/fsm_prog_core_if.sv
// fsm_prog_core_if: configuration, step and status bundle for fsm_prog_core.
//   master drives in_data, step_en, cfg_we, cfg_addr ({state, input}), cfg_ns, cfg_out, cfg_lock;
//   slave drives locked, cfg_err, state, out_data, trans_cnt.
interface fsm_prog_core_if #(
  parameter int IN_W  = 2,
  parameter int ST_W  = 2,
  parameter int OUT_W = 2,
  parameter int CNT_W = 8
);
  logic [IN_W-1:0]      in_data;
  logic                 step_en;
  logic                 cfg_we;
  logic [ST_W+IN_W-1:0] cfg_addr;
  logic [ST_W-1:0]      cfg_ns;
  logic [OUT_W-1:0]     cfg_out;
  logic                 cfg_lock;
  logic                 locked;
  logic                 cfg_err;
  logic [ST_W-1:0]      state;
  logic [OUT_W-1:0]     out_data;
  logic [CNT_W-1:0]     trans_cnt;
  modport master (
    output in_data, step_en, cfg_we, cfg_addr, cfg_ns, cfg_out, cfg_lock,
    input  locked, cfg_err, state, out_data, trans_cnt
  );
  modport slave (
    input  in_data, step_en, cfg_we, cfg_addr, cfg_ns, cfg_out, cfg_lock,
    output locked, cfg_err, state, out_data, trans_cnt
  );
endinterface

// File: rtl/fsm_prog_core.sv
// fsm_prog_core: table-driven FSM, loaded while unlocked, stepped once locked.
//   clk, rst (async, active-high); bus (fsm_prog_core_if.slave) carries config, step and status.
//   Define FSM_PROG_TRANS_CNT_EN to build the saturating transition counter; otherwise trans_cnt is 0.
module fsm_prog_core #(
  parameter int              IN_W        = 2,
  parameter int              ST_W        = 2,
  parameter int              OUT_W       = 2,
  parameter logic [ST_W-1:0] RESET_STATE = '0,
  parameter int              CNT_W       = 8
) (
  input logic            clk,
  input logic            rst,
  fsm_prog_core_if.slave bus
);
  localparam int AW = ST_W + IN_W;
  localparam int N  = 1 << AW;
  typedef enum logic {CFG, RUN} phase_t;
  phase_t           r_phase;
  logic [ST_W-1:0]  r_ns [N];
  logic [OUT_W-1:0] r_tout [N];
  logic [ST_W-1:0]  r_state;
  logic [OUT_W-1:0] r_out;
  logic             r_err;
  logic [AW-1:0]    w_idx;
  logic [ST_W-1:0]  w_ns;
  assign w_idx = {r_state, bus.in_data};
  assign w_ns  = r_ns[w_idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_phase <= CFG;
      r_state <= RESET_STATE;
      r_out   <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_ns[i]   <= RESET_STATE;
        r_tout[i] <= '0;
      end
    end else if (r_phase == CFG) begin
      if (bus.cfg_we) begin
        r_ns[bus.cfg_addr]   <= bus.cfg_ns;
        r_tout[bus.cfg_addr] <= bus.cfg_out;
      end
      if (bus.cfg_lock) r_phase <= RUN;
    end else begin
      if (bus.cfg_we) r_err <= 1'b1;
      if (bus.step_en) begin
        r_state <= w_ns;
        r_out   <= r_tout[w_idx];
      end
    end
`ifdef FSM_PROG_TRANS_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (r_phase == RUN && bus.step_en && w_ns != r_state && r_cnt != {CNT_W{1'b1}})
      r_cnt <= r_cnt + 1'b1;
  assign bus.trans_cnt = r_cnt;
`else
  assign bus.trans_cnt = {CNT_W{1'b0}};
`endif
  assign bus.locked   = (r_phase == RUN);
  assign bus.cfg_err  = r_err;
  assign bus.state    = r_state;
  assign bus.out_data = r_out;
endmodule

// File: tb/tb_fsm_prog_core.sv
// tb_fsm_prog_core: directed table-driven checks of fsm_prog_core (default and CNT_W=2 instances).
module tb_fsm_prog_core;
`ifdef FSM_PROG_TRANS_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  fsm_prog_core_if #(.CNT_W(8)) m();
  fsm_prog_core_if #(.CNT_W(2)) n();
  fsm_prog_core #(.CNT_W(8)) u_m (.clk(clk), .rst(rst), .bus(m));
  fsm_prog_core #(.CNT_W(2)) u_n (.clk(clk), .rst(rst), .bus(n));
  typedef struct {
    logic [1:0] in;
    logic       en;
    logic [1:0] st;
    logic [1:0] od;
    int         cnt;
  } vec_t;
  vec_t v[12];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int ce(input int c);
    return CNT_ON ? c : 0;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic idle_m();
    m.in_data = '0; m.step_en = 0; m.cfg_we = 0; m.cfg_addr = '0;
    m.cfg_ns = '0; m.cfg_out = '0; m.cfg_lock = 0;
  endtask
  task automatic wr_m(input logic [3:0] a, input logic [1:0] ns, input logic [1:0] o, input logic lk);
    m.cfg_we = 1; m.cfg_addr = a; m.cfg_ns = ns; m.cfg_out = o; m.cfg_lock = lk;
    tick();
    m.cfg_we = 0; m.cfg_lock = 0;
  endtask
  task automatic step_m(input logic [1:0] i);
    m.in_data = i; m.step_en = 1;
    tick();
    m.step_en = 0;
  endtask
  initial begin
    logic [1:0] st, in;
    v[0]  = '{2'd3, 1'b1, 2'd1, 2'd1, 1};
    v[1]  = '{2'd3, 1'b1, 2'd2, 2'd3, 2};
    v[2]  = '{2'd3, 1'b1, 2'd3, 2'd1, 3};
    v[3]  = '{2'd3, 1'b1, 2'd0, 2'd3, 4};
    v[4]  = '{2'd3, 1'b1, 2'd1, 2'd1, 5};
    v[5]  = '{2'd0, 1'b1, 2'd1, 2'd2, 5};
    v[6]  = '{2'd1, 1'b1, 2'd1, 2'd3, 5};
    v[7]  = '{2'd2, 1'b1, 2'd1, 2'd2, 5};
    v[8]  = '{2'd3, 1'b0, 2'd1, 2'd2, 5};
    v[9]  = '{2'd3, 1'b1, 2'd2, 2'd3, 6};
    v[10] = '{2'd3, 1'b1, 2'd3, 2'd1, 7};
    v[11] = '{2'd3, 1'b1, 2'd0, 2'd3, 8};
    idle_m();
    n.in_data = '0; n.step_en = 0; n.cfg_we = 0; n.cfg_addr = '0;
    n.cfg_ns = '0; n.cfg_out = '0; n.cfg_lock = 0;
    tick(); tick();
    chk("rst_state", m.state, 0);
    chk("rst_out", m.out_data, 0);
    chk("rst_locked", m.locked, 0);
    chk("rst_err", m.cfg_err, 0);
    chk("rst_cnt", m.trans_cnt, 0);
    rst = 0;
    for (int a = 0; a < 16; a++) begin
      st = a[3:2]; in = a[1:0];
      wr_m(a[3:0], (in == 2'd3) ? st + 2'd1 : st, {st[0], in[0]}, 1'b0);
    end
    m.in_data = 2'd3; m.step_en = 1;
    tick(); tick();
    m.step_en = 0;
    chk("unlocked_step_state", m.state, 0);
    chk("unlocked_step_out", m.out_data, 0);
    chk("unlocked_locked", m.locked, 0);
    m.cfg_lock = 1;
    tick();
    m.cfg_lock = 0;
    chk("lock_rise", m.locked, 1);
    chk("lock_no_err", m.cfg_err, 0);
    for (int i = 0; i < 12; i++) begin
      m.in_data = v[i].in; m.step_en = v[i].en;
      tick();
      chk($sformatf("vec%0d_state", i), m.state, v[i].st);
      chk($sformatf("vec%0d_out", i), m.out_data, v[i].od);
      chk($sformatf("vec%0d_cnt", i), m.trans_cnt, ce(v[i].cnt));
    end
    m.step_en = 0; m.in_data = 2'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_state", m.state, 0);
      chk("hold_out", m.out_data, 3);
    end
    chk("hold_cnt", m.trans_cnt, ce(8));
    chk("lock_sticky", m.locked, 1);
    wr_m(4'd0, 2'd2, 2'd3, 1'b0);
    chk("wr_locked_err", m.cfg_err, 1);
    step_m(2'd0);
    chk("wr_locked_state", m.state, 0);
    chk("wr_locked_out", m.out_data, 0);
    chk("err_sticky", m.cfg_err, 1);
    step_m(2'd3); step_m(2'd3); step_m(2'd3);
    chk("pre_rst_state", m.state, 3);
    chk("pre_rst_cnt", m.trans_cnt, ce(11));
    #2 rst = 1;
    #1;
    chk("async_rst_state", m.state, 0);
    chk("async_rst_out", m.out_data, 0);
    chk("async_rst_locked", m.locked, 0);
    chk("async_rst_err", m.cfg_err, 0);
    chk("async_rst_cnt", m.trans_cnt, 0);
    tick();
    rst = 0;
    m.cfg_lock = 1;
    tick();
    m.cfg_lock = 0;
    step_m(2'd3);
    chk("table_cleared_state", m.state, 0);
    chk("table_cleared_out", m.out_data, 0);
    rst = 1;
    tick();
    rst = 0;
    wr_m(4'd0, 2'd3, 2'd2, 1'b1);
    chk("wr_lock_locked", m.locked, 1);
    chk("wr_lock_err", m.cfg_err, 0);
    step_m(2'd0);
    chk("wr_lock_state", m.state, 3);
    chk("wr_lock_out", m.out_data, 2);
    chk("wr_lock_err2", m.cfg_err, 0);
    chk("wr_lock_cnt", m.trans_cnt, ce(1));
    n.cfg_we = 1; n.cfg_addr = 4'd0; n.cfg_ns = 2'd1; n.cfg_out = 2'd1;
    tick();
    n.cfg_addr = 4'd4; n.cfg_ns = 2'd0; n.cfg_out = 2'd2; n.cfg_lock = 1;
    tick();
    n.cfg_we = 0; n.cfg_lock = 0;
    chk("sat_locked", n.locked, 1);
    n.in_data = 2'd0; n.step_en = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("sat%0d_state", i), n.state, i % 2);
      chk($sformatf("sat%0d_cnt", i), n.trans_cnt, ce(i < 3 ? i : 3));
    end
    n.step_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsm_prog_core.md
# fsm_prog_core

Programmable, clocked finite-state-machine core: the parametrised successor to our fixed two-input, two-state-bit gate-level FSM benchmarks. Instead of hard-wired next-state/output logic, it holds a next-state/output table that is loaded through a configuration port and then locked. Once locked, it steps one transition per enabled clock. It is the common engine for generating, locking and exercising FSM benchmark instances of arbitrary input, state and output width.

## Interface
Parameters:
- IN_W, default 2: number of primary input bits.
- ST_W, default 2: number of state bits. The table holds 2^(ST_W+IN_W) entries.
- OUT_W, default 2: number of output bits.
- RESET_STATE, default 0: state loaded on reset (ST_W bits).
- CNT_W, default 8: width of the transition counter.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  IN_W  primary inputs, sampled on a step.
- step_en  in  1  advance the FSM by one transition this cycle.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  ST_W+IN_W  table index, formed as {state, input}.
- cfg_ns  in  ST_W  next-state field to write.
- cfg_out  in  OUT_W  output field to write.
- cfg_lock  in  1  request lock (sticky).
- locked  out  1  table locked; FSM may step.
- cfg_err  out  1  sticky flag: a write was attempted while locked.
- state  out  ST_W  current state register.
- out_data  out  OUT_W  registered Mealy output of the last step.
- trans_cnt  out  CNT_W  count of steps that changed state (saturating).

## Operation
- Reset values: state=RESET_STATE, out_data=0, locked=0, cfg_err=0, trans_cnt=0. Every table entry resets to ns=RESET_STATE, out=0.
- Unlocked phase:
  - cfg_we=1 writes {cfg_ns, cfg_out} to entry cfg_addr at the clock edge.
  - step_en is ignored; state and out_data hold.
- Lock:
  - cfg_lock=1 at an edge sets locked=1.
  - locked stays 1 until rst; deasserting cfg_lock has no effect.
  - If cfg_we and cfg_lock are both high in the same unlocked cycle, the write is performed and locked rises at that same edge.
- Locked phase:
  - cfg_we=1 is ignored; the table is unchanged and cfg_err is set (sticky until rst).
  - step_en=1: the core reads entry e = table[{state, in_data}], then sets state<=e.ns and out_data<=e.out.
  - step_en=0: state, out_data and trans_cnt hold.
- Transition counter:
  - Increments on a step where e.ns != state.
  - Saturates at 2^CNT_W-1; it does not wrap.
- Index packing: state occupies the MSBs of cfg_addr and in_data the LSBs.
- Reset mid-operation: rst asserted at any time clears all state, outputs, lock and table asynchronously, with no clock required. Configuration must be reloaded afterwards.

## Timing
- Step latency is 1 cycle: in_data sampled at edge k produces state and out_data updated after edge k and visible in cycle k+1.
- Back-to-back steps are supported every cycle.
- Table write latency is 1 cycle. Step reads always use table contents as they were before the edge; write-during-step cannot occur because of the lock.
- locked, cfg_err and trans_cnt are registered and update at the same edge as their cause.
- rst deassertion is synchronised externally. The first edge after deassertion may carry a write or lock.

## Configuration
- FSM_PROG_TRANS_CNT_EN:
  - Defined: the trans_cnt register and its saturating increment logic are built as specified above.
  - Undefined: trans_cnt is tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- Reset and defaults: assert rst mid-run with locked=1, state=3 -> immediately state=0, out_data=0, locked=0, cfg_err=0, trans_cnt=0.
- Load and step (default params):
  - Load the 16-entry table with ns=(state+1)%4 when in_data=2'b11, else ns=state; out={state[0], in_data[0]}.
  - Lock, then drive in_data=3 for 5 steps -> state sequence 1,2,3,0,1; trans_cnt=5.
  - Then drive in_data=0 -> state holds at 1 and trans_cnt stays 5.
- Step gating:
  - step_en=1 while unlocked -> state and out_data unchanged.
  - step_en=0 while locked for 10 cycles -> no change.
- Write after lock: write entry 0 with ns=2 after locking -> cfg_err=1 and entry 0 unchanged (a step from state 0 with in_data=0 still yields its old ns). cfg_err stays 1 until rst.
- Simultaneous write and lock: cfg_we (addr 0, ns=3, out=2) together with cfg_lock -> locked=1 next cycle; a step from state 0 with in_data=0 gives state=3, out_data=2; cfg_err=0.
- Saturation: CNT_W=2, alternate between states 0 and 1 for 6 steps -> trans_cnt reaches 3 and stays 3. With FSM_PROG_TRANS_CNT_EN undefined -> trans_cnt=0 throughout.
